controlador_memoria_ram: RTL and testbench
==========================================

Name: controlador_memoria_ram

Overview:
Host-side controller (initiator) for a small synchronous word RAM built from the team's flip-flop storage cells. It accepts read, write and clear-all commands from a host over a valid/ready command interface and sequences the RAM port strobes. It returns one response pulse per command. It sits between the datapath or testbench host and the RAM array, and is the reader/writer counterpart to the storage block.

Parameters:
ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
DATA_W, 8, word width
READ_LATENCY, 1, edges from the RAM sampling a read strobe to mem_rdata being valid (range 1..4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  host presents a command
cmd_ready  output  1  controller can accept; high only in IDLE
cmd_op  input  2  00 read, 01 write, 10 clear-all, 11 reserved
cmd_addr  input  ADDR_W  target address (ignored for clear-all)
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  single-cycle response pulse; no backpressure
rsp_data  output  DATA_W  read data; 0 for non-read responses
rsp_err  output  1  qualifies rsp_valid; 1 only for reserved op
busy  output  1  high in any state other than IDLE
mem_en  output  1  RAM access strobe, one cycle per access
mem_we  output  1  1 = write, 0 = read; meaningful only with mem_en
mem_addr  output  ADDR_W  RAM address
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs 0 except cmd_ready=1. Internal counters and registers are cleared.
- Reset mid-operation aborts the command with no response. A partially completed clear leaves the RAM partially cleared.
- Acceptance: a command is accepted at edge E0 when cmd_valid && cmd_ready. cmd_* are registered at E0. Host signals are don't-care while busy.
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, CLEAR, RESP.
- Write:
  - After E0 (WRITE): mem_en=1, mem_we=1, mem_addr and mem_wdata set from the registered command.
  - At E1: go to RESP. rsp_valid=1, rsp_data=0, rsp_err=0 for one cycle.
  - At E2: return to IDLE.
- Read:
  - After E0 (READ_ISSUE): mem_en=1, mem_we=0, mem_addr=addr.
  - At E1: go to READ_WAIT, with a counter loaded to READ_LATENCY.
  - At edge E1+READ_LATENCY: capture mem_rdata into rsp_data and enter RESP.
  - With READ_LATENCY=1, rsp_valid is high between E2 and E3.
- Clear-all:
  - CLEAR issues DEPTH consecutive write strobes: mem_we=1, mem_wdata=0, mem_addr=0,1,…,DEPTH-1 after edges E0..E(DEPTH-1). The address counter increments each edge.
  - At E(DEPTH): go to RESP with rsp_data=0.
- Reserved op: no RAM access. At E0 go directly to RESP with rsp_err=1, rsp_data=0.
- Outside the strobe cycles: mem_en=0, mem_we=0; mem_addr and mem_wdata hold their last values.
- rsp_data holds its value after RESP until the next response. rsp_valid and rsp_err are 0 outside RESP.
- Throughput: back-to-back commands are not allowed; cmd_ready rises in the cycle after RESP.
- Widths: addresses wrap modulo DEPTH. The clear counter is ADDR_W+1 bits so it can reach the terminal count DEPTH.

Decomposition:
- Shared package: op encodings (OP_READ, OP_WRITE, OP_CLEAR, OP_RSVD), state encodings, and the default ADDR_W/DATA_W.
- Single RTL module; no sub-module is warranted.
- The bench supplies a behavioural RAM model with READ_LATENCY-deep output registers.

Test Plan:
- Reset, then write addr 2 data 8'hAA -> one mem_en/mem_we strobe at addr 2 after E0; rsp_valid after E1 with rsp_data=0, rsp_err=0; cmd_ready=1 after E2.
- Read addr 2 after that write -> strobe with mem_we=0 at addr 2; rsp_valid after E2 with rsp_data=8'hAA.
- Write 8'h11, 8'h22, 8'h33, 8'h44 to addrs 0..3, then clear-all -> four write strobes addr 0..3 with data 0; rsp after E4; a subsequent read of each address returns 8'h00.
- cmd_op=11 -> no mem_en; rsp_valid after E0 with rsp_err=1, rsp_data=0.
- cmd_valid held high during a read -> cmd_ready=0 and no second accept until IDLE; exactly one response.
- Assert reset during CLEAR after two strobes -> outputs zero immediately, no response; addrs 0–1 read as 0 and addrs 2–3 keep old data.

Source files
------------

// File: rtl/controlador_memoria_ram_pkg.sv
// Shared encodings for the RAM host controller: command opcodes, FSM states
// and default geometry.
package controlador_memoria_ram_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_ISSUE = 3'd2,
        ST_READ_WAIT  = 3'd3,
        ST_CLEAR      = 3'd4,
        ST_RESP       = 3'd5
    } state_e;

endpackage

// File: rtl/controlador_memoria_ram.sv
// Host-side initiator for a small synchronous word RAM: accepts read, write and
// clear-all commands, sequences the RAM strobes and returns one response each.
module controlador_memoria_ram
    import controlador_memoria_ram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CLR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_reg;
    // One bit wider than the address so it can reach the terminal count DEPTH.
    logic [ADDR_W:0]   clr_cnt_reg;
    logic [2:0]        lat_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            clr_cnt_reg <= '0;
            lat_cnt_reg <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        case (op_e'(cmd_op))
                            OP_WRITE: begin
                                state_reg <= ST_WRITE;
                                mem_en    <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= cmd_addr;
                                mem_wdata <= cmd_wdata;
                            end
                            OP_READ: begin
                                state_reg <= ST_READ_ISSUE;
                                mem_en    <= 1'b1;
                                mem_we    <= 1'b0;
                                mem_addr  <= cmd_addr;
                            end
                            OP_CLEAR: begin
                                state_reg   <= ST_CLEAR;
                                mem_en      <= 1'b1;
                                mem_we      <= 1'b1;
                                mem_addr    <= '0;
                                mem_wdata   <= '0;
                                clr_cnt_reg <= CLR_ONE;
                            end
                            default: begin
                                // Reserved op: answer with an error, never touch the RAM.
                                state_reg <= ST_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    state_reg <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                end
                ST_READ_ISSUE: begin
                    mem_en      <= 1'b0;
                    state_reg   <= ST_READ_WAIT;
                    lat_cnt_reg <= READ_LATENCY[2:0];
                end
                ST_READ_WAIT: begin
                    if (lat_cnt_reg == 3'd1) begin
                        rsp_data  <= mem_rdata;
                        rsp_valid <= 1'b1;
                        state_reg <= ST_RESP;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 3'd1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        mem_addr    <= clr_cnt_reg[ADDR_W-1:0];
                        clr_cnt_reg <= clr_cnt_reg + CLR_ONE;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_memoria_ram.sv
// Directed bench for controlador_memoria_ram with a behavioural RAM whose read
// data passes through READ_LATENCY output registers.
module tb_controlador_memoria_ram;
    import controlador_memoria_ram_pkg::*;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 8;
    localparam int RL     = 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    controlador_memoria_ram #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: not reset, so an aborted clear leaves its contents.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rd_pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    // Presents one command for exactly one accepting edge; returns just after E0.
    task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        send(OP_WRITE, a, d);
        repeat (3) @(negedge clk);
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output logic found);
        send(OP_READ, a, '0);
        found = 1'b0;
        d = '0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                d = rsp_data;
            end
        end
        @(negedge clk);
        $display("read  addr=%0d data=%02h found=%0d", a, d, found);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_data, mem_en, mem_we, mem_addr, mem_wdata}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b busy=%b rv=%b err=%b en=%b we=%b", cmd_ready, busy, rsp_valid, rsp_err, mem_en, mem_we);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, mem_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_idle: got rdy=%b busy=%b en=%b want 1 0 0", cmd_ready, busy, mem_en);
        end
        $display("reset done");
    endtask

    task automatic test_write;
        send(OP_WRITE, 2'd2, 8'hAA);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cmd_ready, busy, rsp_valid}
            !== {1'b1, 1'b1, 2'd2, 8'hAA, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL write_strobe: got en=%b we=%b a=%0d d=%02h rdy=%b busy=%b rv=%b", mem_en, mem_we, mem_addr, mem_wdata, cmd_ready, busy, rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_en, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL write_rsp: got en=%b rv=%b err=%b data=%02h want 0 1 0 00", mem_en, rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_idle: got rdy=%b busy=%b rv=%b want 1 0 0", cmd_ready, busy, rsp_valid);
        end
        $display("write addr=2 data=aa checked");
    endtask

    task automatic test_read;
        send(OP_READ, 2'd2, 8'h00);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, rsp_valid} !== {1'b1, 1'b0, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL read_strobe: got en=%b we=%b a=%0d rv=%b", mem_en, mem_we, mem_addr, rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_en, rsp_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL read_wait: got en=%b rv=%b busy=%b want 0 0 1", mem_en, rsp_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'hAA}) begin
            n_fail++;
            $display("FAIL read_rsp: got rv=%b err=%b data=%02h want 1 0 aa", rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_data} !== {1'b1, 1'b0, 8'hAA}) begin
            n_fail++;
            $display("FAIL read_hold: got rdy=%b rv=%b data=%02h want 1 0 aa", cmd_ready, rsp_valid, rsp_data);
        end
        $display("read addr=2 checked");
    endtask

    task automatic test_clear;
        logic [DATA_W-1:0] d;
        logic found;
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(8'h11 * (i + 1)));
        do_read(2'd3, d, found);
        n_checks++;
        if ({found, d} !== {1'b1, 8'h44}) begin
            n_fail++;
            $display("FAIL clear_pre: got found=%b data=%02h want 1 44", found, d);
        end
        send(OP_CLEAR, 2'd3, 8'h99);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata, rsp_valid}
                !== {1'b1, 1'b1, ADDR_W'(k), 8'h00, 1'b0}) begin
                n_fail++;
                $display("FAIL clear_strobe%0d: got en=%b we=%b a=%0d d=%02h rv=%b", k, mem_en, mem_we, mem_addr, mem_wdata, rsp_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({mem_en, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_rsp: got en=%b rv=%b err=%b data=%02h want 0 1 0 00", mem_en, rsp_valid, rsp_err, rsp_data);
        end
        @(negedge clk);
        $display("clear-all issued");
        for (int i = 0; i < DEPTH; i++) begin
            do_read(ADDR_W'(i), d, found);
            n_checks++;
            if ({found, d} !== {1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL clear_readback%0d: got found=%b data=%02h want 1 00", i, found, d);
            end
        end
    endtask

    task automatic test_reserved;
        send(OP_RSVD, 2'd1, 8'h77);
        @(negedge clk);
        n_checks++;
        if ({mem_en, rsp_valid, rsp_err, rsp_data, cmd_ready, busy}
            !== {1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rsvd_rsp: got en=%b rv=%b err=%b data=%02h rdy=%b busy=%b", mem_en, rsp_valid, rsp_err, rsp_data, cmd_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_en, rsp_valid, rsp_err, cmd_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rsvd_idle: got en=%b rv=%b err=%b rdy=%b want 0 0 0 1", mem_en, rsp_valid, rsp_err, cmd_ready);
        end
        $display("reserved op checked");
    endtask

    task automatic test_hold_valid;
        int n_strobe;
        int n_rsp;
        int n_ready;
        logic [DATA_W-1:0] d;
        n_strobe = 0;
        n_rsp = 0;
        n_ready = 0;
        d = '0;
        do_write(2'd3, 8'h5C);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = 2'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_en) n_strobe++;
            if (rsp_valid) begin
                n_rsp++;
                d = rsp_data;
            end
            if (k < 3 && cmd_ready) n_ready++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if ({n_strobe[3:0], n_rsp[3:0], n_ready[3:0], d, cmd_ready}
            !== {4'd1, 4'd1, 4'd0, 8'h5C, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_valid: got strobes=%0d rsps=%0d early_ready=%0d data=%02h rdy=%b want 1 1 0 5c 1", n_strobe, n_rsp, n_ready, d, cmd_ready);
        end
        @(negedge clk);
        $display("held-valid read checked");
    endtask

    task automatic test_reset_mid_clear;
        logic [DATA_W-1:0] d;
        logic found;
        logic [DATA_W-1:0] exp [DEPTH];
        exp[0] = 8'h00; exp[1] = 8'h00; exp[2] = 8'hA2; exp[3] = 8'hA3;
        for (int i = 0; i < DEPTH; i++) do_write(ADDR_W'(i), DATA_W'(8'hA0 + i));
        send(OP_CLEAR, 2'd0, 8'h00);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL midclr_pos: got en=%b we=%b a=%0d want 1 1 2", mem_en, mem_we, mem_addr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_data, mem_en, mem_we, mem_addr, mem_wdata}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL midclr_async: got rdy=%b busy=%b rv=%b en=%b we=%b a=%0d", cmd_ready, busy, rsp_valid, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, mem_en, cmd_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL midclr_norsp: got rv=%b en=%b rdy=%b want 0 0 1", rsp_valid, mem_en, cmd_ready);
        end
        reset = 1'b0;
        $display("reset asserted mid-clear");
        for (int i = 0; i < DEPTH; i++) begin
            do_read(ADDR_W'(i), d, found);
            n_checks++;
            if ({found, d} !== {1'b1, exp[i]}) begin
                n_fail++;
                $display("FAIL midclr_readback%0d: got found=%b data=%02h want 1 %02h", i, found, d, exp[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_write;
        test_read;
        test_clear;
        test_reserved;
        test_hold_valid;
        test_reset_mid_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
